// File: rtl/ram_burst_master_pkg.sv
// Shared parameters and types for the RAM burst initiator and its read-return FIFO.
package ram_burst_master_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int ADDR_BUS_WIDTH = 8;
    localparam int LEN_WIDTH      = 4;
    localparam int MAX_MEM_LOC    = 2 ** ADDR_BUS_WIDTH;
    localparam int FIFO_DEPTH     = 3;
    localparam int CNT_WIDTH      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_WIDTH      = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } rd_beat_t;

endpackage

// File: rtl/ram_rd_fifo.sv
// Three-entry FIFO carrying read beats (data plus end-of-burst flag) from the RAM to the read stream.
module ram_rd_fifo
    import ram_burst_master_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  rd_beat_t             push_beat,
    input  logic                 pop,
    output rd_beat_t             head,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] count
);

    rd_beat_t               mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign do_push = push && (count != CNT_WIDTH'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // NOTE: the storage array is deliberately left out of reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_beat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for the single-port synchronous RAM: write bursts from a valid/ready beat stream,
// read bursts returned through a small FIFO onto a valid/ready stream with backpressure.
module ram_burst_master
    import ram_burst_master_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_BUS_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_last,
    output logic                      done,
    output logic                      ram_read_en,
    output logic                      ram_write_en,
    output logic [ADDR_BUS_WIDTH-1:0] ram_address_loc,
    output logic [DATA_WIDTH-1:0]     ram_data_inbit,
    input  logic [DATA_WIDTH-1:0]     ram_data_outbit
);

    state_t                    state;
    state_t                    state_next;
    logic [ADDR_BUS_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]      beats_left;
    logic                      inflight;
    logic                      inflight_last;
    logic                      cmd_accept;
    logic                      wr_accept;
    logic                      rd_handoff;
    logic                      last_beat;
    logic                      fifo_empty;
    logic [CNT_WIDTH-1:0]      fifo_count;
    rd_beat_t                  push_beat;
    rd_beat_t                  head;

    assign cmd_accept = cmd_valid && cmd_ready;
    assign wr_accept  = wr_valid && wr_ready;
    assign rd_handoff = rd_valid && rd_ready;
    assign last_beat  = (beats_left == '0);

    always_comb begin
        state_next  = state;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        ram_read_en = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = cmd_write ? WRITE : READ;
            end
            WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid && last_beat) state_next = IDLE;
            end
            READ: begin
                // Beats queued plus the one returning from the RAM must leave a free FIFO slot.
                ram_read_en = (3'(fifo_count) + 3'(inflight)) < 3'(FIFO_DEPTH);
                if (ram_read_en && last_beat) state_next = DRAIN;
            end
            DRAIN: begin
                if (rd_handoff && rd_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ram_write_en    = wr_accept;
    assign ram_address_loc = (ram_write_en || ram_read_en) ? cur_addr : '0;
    assign ram_data_inbit  = ram_write_en ? wr_data : '0;

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cur_addr      <= '0;
            beats_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_next;
            inflight      <= ram_read_en;
            inflight_last <= ram_read_en && last_beat;
            done          <= (wr_accept && last_beat) || (rd_handoff && rd_last);
            if (cmd_accept) begin
                cur_addr   <= cmd_addr;
                beats_left <= cmd_len;
            end else if (ram_write_en || ram_read_en) begin
                cur_addr   <= cur_addr + ADDR_BUS_WIDTH'(1);
                beats_left <= beats_left - LEN_WIDTH'(1);
            end
        end
    end

    assign push_beat.last = inflight_last;
    assign push_beat.data = ram_data_outbit;

    ram_rd_fifo u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_beat (push_beat),
        .pop       (rd_handoff),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rd_valid = !fifo_empty;
    assign rd_data  = head.data;
    assign rd_last  = head.last;

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: behavioural RAM, transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bursts.
module tb_ram_burst_master;
    import ram_burst_master_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [ADDR_BUS_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]      cmd_len;
    logic                      wr_valid;
    logic                      wr_ready;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      rd_valid;
    logic                      rd_ready;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      rd_last;
    logic                      done;
    logic                      ram_read_en;
    logic                      ram_write_en;
    logic [ADDR_BUS_WIDTH-1:0] ram_address_loc;
    logic [DATA_WIDTH-1:0]     ram_data_inbit;
    logic [DATA_WIDTH-1:0]     ram_data_outbit;

    ram_burst_master dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_data         (wr_data),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .rd_data         (rd_data),
        .rd_last         (rd_last),
        .done            (done),
        .ram_read_en     (ram_read_en),
        .ram_write_en    (ram_write_en),
        .ram_address_loc (ram_address_loc),
        .ram_data_inbit  (ram_data_inbit),
        .ram_data_outbit (ram_data_outbit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_WIDTH-1:0] init_byte(input int i);
        return DATA_WIDTH'((i * 29 + 7) ^ (i >> 2));
    endfunction

    // Behavioural single-port RAM; output shows a poison value whenever no read was issued.
    logic [DATA_WIDTH-1:0] ram_mem [MAX_MEM_LOC];
    bit ram_init_done = 1'b0;
    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < MAX_MEM_LOC; i++) ram_mem[i] <= init_byte(i);
            ram_init_done <= 1'b1;
        end else if (ram_write_en) begin
            ram_mem[ram_address_loc] <= ram_data_inbit;
        end
        ram_data_outbit <= ram_read_en ? ram_mem[ram_address_loc] : 8'hEE;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference model state
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } exp_beat_t;

    logic [DATA_WIDTH-1:0]     mem_model [MAX_MEM_LOC];
    bit                        model_init_done = 1'b0;
    bit                        busy;
    bit                        done_due;
    int                        wr_left;
    int                        iss_left;
    int                        outstanding;
    logic [ADDR_BUS_WIDTH-1:0] wr_addr_m;
    logic [ADDR_BUS_WIDTH-1:0] iss_addr_m;
    logic [DATA_WIDTH-1:0]     exp_wdata_q [$];
    exp_beat_t                 exp_rd_q [$];
    bit                        prev_stall;
    logic [DATA_WIDTH-1:0]     prev_data;
    logic                      prev_last;

    // Logs used by the directed scenarios
    int                        accept_cyc;
    int                        first_rv_cyc;
    bit                        first_rv_pending;
    int                        done_cnt = 0;
    int                        we_cnt = 0;
    int                        handoff_cnt = 0;
    int                        handoff_cyc_q [$];
    logic [DATA_WIDTH-1:0]     rd_log_q [$];
    logic                      rd_last_log_q [$];
    logic [ADDR_BUS_WIDTH-1:0] wr_addr_log_q [$];

    always @(negedge clk) begin
        if (!model_init_done) begin
            for (int i = 0; i < MAX_MEM_LOC; i++) mem_model[i] = init_byte(i);
            model_init_done = 1'b1;
        end
        if (rst) begin
            busy = 1'b0;
            done_due = 1'b0;
            wr_left = 0;
            iss_left = 0;
            outstanding = 0;
            exp_rd_q.delete();
            exp_wdata_q.delete();
            prev_stall = 1'b0;
            first_rv_pending = 1'b0;
        end else begin
            check("cmd_ready", cmd_ready, !busy);
            check("done", done, done_due);
            if (done) done_cnt++;
            done_due = 1'b0;
            check("rw_exclusive", ram_read_en && ram_write_en, 0);
            check("wr_ready", wr_ready, wr_left > 0);
            check("ram_write_en", ram_write_en, (wr_left > 0) && wr_valid);
            check("ram_read_en", ram_read_en, (iss_left > 0) && (outstanding < 3));

            if (ram_write_en) begin
                we_cnt++;
                wr_addr_log_q.push_back(ram_address_loc);
            end
            if (ram_write_en && wr_left > 0 && exp_wdata_q.size() > 0) begin
                check("wr_addr", ram_address_loc, wr_addr_m);
                check("wr_data", ram_data_inbit, exp_wdata_q[0]);
                mem_model[wr_addr_m] = exp_wdata_q.pop_front();
                wr_addr_m++;
                wr_left--;
                if (wr_left == 0) begin
                    busy = 1'b0;
                    done_due = 1'b1;
                end
            end

            if (ram_read_en && iss_left > 0) begin
                check("rd_addr", ram_address_loc, iss_addr_m);
                iss_addr_m++;
                iss_left--;
                outstanding++;
            end

            if (prev_stall) begin
                check("rd_hold_valid", rd_valid, 1);
                check("rd_hold_data", rd_data, prev_data);
                check("rd_hold_last", rd_last, prev_last);
            end

            if (rd_valid) begin
                if (first_rv_pending) begin
                    first_rv_cyc = cyc;
                    first_rv_pending = 1'b0;
                end
                check("rd_expected", exp_rd_q.size() > 0, 1);
                if (exp_rd_q.size() > 0) begin
                    check("rd_data", rd_data, exp_rd_q[0].data);
                    check("rd_last", rd_last, exp_rd_q[0].last);
                    if (rd_ready) begin
                        if (exp_rd_q[0].last) begin
                            busy = 1'b0;
                            done_due = 1'b1;
                        end
                        void'(exp_rd_q.pop_front());
                        outstanding--;
                        handoff_cnt++;
                        handoff_cyc_q.push_back(cyc);
                        rd_log_q.push_back(rd_data);
                        rd_last_log_q.push_back(rd_last);
                    end
                end
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            prev_last  = rd_last;
            check("outstanding_le3", outstanding <= 3, 1);

            if (cmd_valid && cmd_ready) begin
                busy = 1'b1;
                accept_cyc = cyc;
                if (cmd_write) begin
                    wr_left = int'(cmd_len) + 1;
                    wr_addr_m = cmd_addr;
                end else begin
                    iss_left = int'(cmd_len) + 1;
                    iss_addr_m = cmd_addr;
                    for (int i = 0; i <= int'(cmd_len); i++)
                        exp_rd_q.push_back('{data: mem_model[ADDR_BUS_WIDTH'(int'(cmd_addr) + i)],
                                             last: (i == int'(cmd_len))});
                    first_rv_pending = 1'b1;
                end
            end
        end
    end

    // rd_ready pattern: 0 = always high, 1 = 1,0,0,1 repeating, 2 = random
    int rr_mode = 0;
    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input bit w, input logic [ADDR_BUS_WIDTH-1:0] a, input logic [LEN_WIDTH-1:0] l);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                tick();
                cmd_valid = 1'b0;
                return;
            end
        end
        cmd_valid = 1'b0;
        timeout_fail("cmd_accept_timeout");
    endtask

    task automatic wait_done(input int start, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (done_cnt > start) return;
            tick();
        end
        timeout_fail("done_timeout");
    endtask

    task automatic write_burst(input logic [ADDR_BUS_WIDTH-1:0] a, input logic [LEN_WIDTH-1:0] l,
                               input int gap, input bit rand_data, input logic [DATA_WIDTH-1:0] base);
        logic [DATA_WIDTH-1:0] d [16];
        int start;
        bit ok;
        start = done_cnt;
        for (int i = 0; i <= int'(l); i++) begin
            d[i] = rand_data ? DATA_WIDTH'($urandom) : base + DATA_WIDTH'(i);
            exp_wdata_q.push_back(d[i]);
        end
        send_cmd(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            repeat (gap) tick();
            wr_valid = 1'b1;
            wr_data  = d[i];
            ok = 1'b0;
            for (int k = 0; k < 100 && !ok; k++) begin
                @(negedge clk);
                ok = wr_ready;
                tick();
            end
            wr_valid = 1'b0;
            if (!ok) timeout_fail("wr_beat_timeout");
        end
        wait_done(start, 100);
    endtask

    task automatic read_burst(input logic [ADDR_BUS_WIDTH-1:0] a, input logic [LEN_WIDTH-1:0] l);
        int start;
        start = done_cnt;
        send_cmd(1'b0, a, l);
        wait_done(start, 600);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_WIDTH-1:0] exp_t1 [4];
        logic [ADDR_BUS_WIDTH-1:0] exp_t4 [4];
        int we0;
        int dn0;
        int hs0;
        bit ok;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        wr_valid = 1'b0;
        wr_data = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_done", done, 0);
        check("rst_ram_read_en", ram_read_en, 0);
        check("rst_ram_write_en", ram_write_en, 0);
        check("rst_ram_address", ram_address_loc, 0);
        check("rst_ram_data_in", ram_data_inbit, 0);
        tick();

        // 1: write A0..A3 at 0x10, read back
        exp_t1 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        dn0 = done_cnt;
        write_burst(8'h10, 4'd3, 0, 1'b0, 8'hA0);
        rd_log_q.delete();
        rd_last_log_q.delete();
        read_burst(8'h10, 4'd3);
        check("t1_beats", rd_log_q.size(), 4);
        for (int i = 0; i < 4 && i < rd_log_q.size(); i++) begin
            check("t1_data", rd_log_q[i], exp_t1[i]);
            check("t1_last", rd_last_log_q[i], (i == 3));
        end
        check("t1_done_count", done_cnt - dn0, 2);

        // 2: read 8 beats with rd_ready high: 3-cycle latency, one beat per cycle
        rr_mode = 0;
        tick();
        handoff_cyc_q.delete();
        read_burst(8'h20, 4'd7);
        check("t2_latency", first_rv_cyc - accept_cyc, 3);
        check("t2_beats", handoff_cyc_q.size(), 8);
        if (handoff_cyc_q.size() == 8)
            check("t2_back_to_back", handoff_cyc_q[7] - handoff_cyc_q[0], 7);

        // 3: read 8 beats with rd_ready toggling 1,0,0,1
        rr_mode = 1;
        rd_log_q.delete();
        read_burst(8'h80, 4'd7);
        check("t3_beats", rd_log_q.size(), 8);
        rr_mode = 0;
        tick();

        // 4: write across the address wrap, read back
        wr_addr_log_q.delete();
        write_burst(8'hFE, 4'd3, 0, 1'b0, 8'h30);
        exp_t4 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        check("t4_writes", wr_addr_log_q.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr_log_q.size(); i++)
            check("t4_wr_addr", wr_addr_log_q[i], exp_t4[i]);
        rd_log_q.delete();
        read_burst(8'hFE, 4'd3);
        check("t4_rd_beats", rd_log_q.size(), 4);
        for (int i = 0; i < 4 && i < rd_log_q.size(); i++)
            check("t4_rd_data", rd_log_q[i], 8'h30 + 8'(i));

        // 5: write with gaps between beats
        we0 = we_cnt;
        dn0 = done_cnt;
        write_burst(8'h50, 4'd3, 2, 1'b1, 8'h00);
        check("t5_write_pulses", we_cnt - we0, 4);
        check("t5_done_count", done_cnt - dn0, 1);

        // 6: reset during a read, after the second beat
        rr_mode = 0;
        hs0 = handoff_cnt;
        dn0 = done_cnt;
        send_cmd(1'b0, 8'h40, 4'd7);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (handoff_cnt >= hs0 + 2) ok = 1'b1;
            else tick();
        end
        if (!ok) timeout_fail("t6_beat2_timeout");
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rd_valid", rd_valid, 0);
        check("t6_cmd_ready", cmd_ready, 1);
        check("t6_done", done, 0);
        check("t6_no_done_pulse", done_cnt - dn0, 0);
        tick();
        rd_log_q.delete();
        read_burst(8'h10, 4'd3);
        check("t6_new_read_beats", rd_log_q.size(), 4);
        if (rd_log_q.size() > 0) check("t6_new_read_first", rd_log_q[0], 8'hA0);

        // Randomized bursts
        for (int n = 0; n < 40; n++) begin
            rr_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1)
                write_burst(ADDR_BUS_WIDTH'($urandom), LEN_WIDTH'($urandom), $urandom_range(0, 2), 1'b1, 8'h00);
            else
                read_burst(ADDR_BUS_WIDTH'($urandom), LEN_WIDTH'($urandom));
        end
        rr_mode = 0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
